mole_scheduler: RTL and testbench

Multi-mole spawn and lifetime controller for the whack-a-mole game.
- Decides when a mole appears, which of NUM_HOLES holes it lights, and how long it stays lit.
- Allows up to MAX_ACTIVE simultaneous moles.
- Sits between the game control FSM (enable, level) and the LED / score path. Consumes the per-hole hammer hit vector; emits per-hole LEDs plus hit/miss pulses for the score counter.

---
 rtl/mole_pkg.sv | 34 +++
 rtl/mole_lfsr16.sv | 32 +++
 rtl/mole_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_mole_scheduler.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mole_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mole_pkg
// Description : Shared encodings and helpers for the whack-a-mole scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package mole_pkg;

    localparam logic [1:0] LVL_EASY = 2'd0;
    localparam logic [1:0] LVL_MED  = 2'd1;
    localparam logic [1:0] LVL_HARD = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        PICK = 2'd2
    } state_t;

    localparam int          LFSR_W    = 16;
    // Galois feedback mask for taps 16,14,13,11 (right-shifting form)
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Holes are at most 8 wide; callers zero-extend their vectors.
    function automatic logic [3:0] popcount(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mole_lfsr16.sv
`default_nettype none
// ============================================================================
// Module      : mole_lfsr16
// Description : Free-running 16-bit Galois LFSR; exposes its low byte.
// Revision    : 1.0 - initial release
// ============================================================================
module mole_lfsr16
    import mole_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] o_rand
);

    logic [LFSR_W-1:0] r_lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= SEED;
        end else if (r_lfsr[0]) begin
            r_lfsr <= (r_lfsr >> 1) ^ LFSR_TAPS;
        end else begin
            r_lfsr <= r_lfsr >> 1;
        end
    end

    assign o_rand = r_lfsr[7:0];

endmodule
`default_nettype wire

// File: rtl/mole_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : mole_scheduler
// Description : Spawns moles into random free holes, times their lifetime and
//               reports hits, misses and spawns. Optional build macro
//               MOLE_SCHED_PENALTY_EN enables wrong_pulse on unlit strikes.
// Revision    : 1.0 - initial release
// ============================================================================
module mole_scheduler
    import mole_pkg::*;
#(
    parameter int          NUM_HOLES        = 5,
    parameter int          MAX_ACTIVE       = 2,
    parameter int          SPAWN_TICKS_EASY = 150_000_000,
    parameter int          SPAWN_TICKS_MED  = 100_000_000,
    parameter int          SPAWN_TICKS_HARD = 50_000_000,
    parameter int          LIFE_TICKS_EASY  = 300_000_000,
    parameter int          LIFE_TICKS_MED   = 200_000_000,
    parameter int          LIFE_TICKS_HARD  = 100_000_000,
    parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [1:0]           level,
    input  logic [NUM_HOLES-1:0] hit_vec,
    output logic [NUM_HOLES-1:0] mole_led,
    output logic                 hit_pulse,
    output logic [2:0]           hit_num,
    output logic                 miss_pulse,
    output logic                 wrong_pulse,
    output logic                 spawn_pulse,
    output logic [3:0]           active_count
);

    localparam int c_MAX_SPAWN = (SPAWN_TICKS_EASY > SPAWN_TICKS_MED)
                               ? ((SPAWN_TICKS_EASY > SPAWN_TICKS_HARD) ? SPAWN_TICKS_EASY : SPAWN_TICKS_HARD)
                               : ((SPAWN_TICKS_MED  > SPAWN_TICKS_HARD) ? SPAWN_TICKS_MED  : SPAWN_TICKS_HARD);
    localparam int c_MAX_LIFE  = (LIFE_TICKS_EASY > LIFE_TICKS_MED)
                               ? ((LIFE_TICKS_EASY > LIFE_TICKS_HARD) ? LIFE_TICKS_EASY : LIFE_TICKS_HARD)
                               : ((LIFE_TICKS_MED  > LIFE_TICKS_HARD) ? LIFE_TICKS_MED  : LIFE_TICKS_HARD);
    localparam int c_MAX_TICKS = (c_MAX_SPAWN > c_MAX_LIFE) ? c_MAX_SPAWN : c_MAX_LIFE;
    localparam int CNT_W       = (c_MAX_TICKS > 1) ? $clog2(c_MAX_TICKS) : 1;
    localparam int c_PROBE_W   = $clog2(NUM_HOLES);

    function automatic logic [CNT_W-1:0] spawn_reload(input logic [1:0] lvl);
        case (lvl)
            LVL_EASY: return CNT_W'(SPAWN_TICKS_EASY - 1);
            LVL_MED:  return CNT_W'(SPAWN_TICKS_MED - 1);
            default:  return CNT_W'(SPAWN_TICKS_HARD - 1);
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] life_reload(input logic [1:0] lvl);
        case (lvl)
            LVL_EASY: return CNT_W'(LIFE_TICKS_EASY - 1);
            LVL_MED:  return CNT_W'(LIFE_TICKS_MED - 1);
            default:  return CNT_W'(LIFE_TICKS_HARD - 1);
        endcase
    endfunction

    state_t                 r_state;
    logic [CNT_W-1:0]       r_spawn_cnt;
    logic [c_PROBE_W-1:0]   r_probe;
    logic [3:0]             r_probe_cnt;

    logic [7:0]             w_rand;
    logic [NUM_HOLES-1:0]   w_hit;
    logic [NUM_HOLES-1:0]   w_timeout;
    logic [NUM_HOLES-1:0]   w_spawn_set;
    logic [NUM_HOLES-1:0]   w_led_next;
    logic [CNT_W-1:0]       w_life_reload;
    logic [3:0]             w_hit_cnt;
    logic                   w_wrong;

    mole_lfsr16 #(
        .SEED   (LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst    (reset),
        .o_rand (w_rand)
    );

    // A hole is judged on the registered LED state, so a hole freed this
    // cycle is still seen as busy by the probe until the next cycle.
    assign w_spawn_set   = (r_state == PICK && !mole_led[r_probe])
                         ? ({{(NUM_HOLES-1){1'b0}}, 1'b1} << r_probe)
                         : '0;
    assign w_life_reload = life_reload(level);
    assign w_led_next    = (mole_led & ~w_hit & ~w_timeout) | w_spawn_set;
    assign w_hit_cnt     = popcount(8'(w_hit));

`ifdef MOLE_SCHED_PENALTY_EN
    assign w_wrong = |(hit_vec & ~mole_led);
`else
    assign w_wrong = 1'b0;
`endif

    for (genvar i = 0; i < NUM_HOLES; i++) begin : g_hole
        logic [CNT_W-1:0] r_life;

        // A strike on the final life cycle counts as a hit, never a miss.
        assign w_hit[i]     = mole_led[i] & hit_vec[i];
        assign w_timeout[i] = mole_led[i] & ~hit_vec[i] & (r_life == '0);

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_life <= '0;
            end else if (!enable) begin
                r_life <= '0;
            end else if (w_spawn_set[i]) begin
                r_life <= w_life_reload;
            end else if (mole_led[i] && r_life != '0) begin
                r_life <= r_life - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_spawn_cnt  <= '0;
            r_probe      <= '0;
            r_probe_cnt  <= '0;
            mole_led     <= '0;
            hit_pulse    <= 1'b0;
            hit_num      <= '0;
            miss_pulse   <= 1'b0;
            wrong_pulse  <= 1'b0;
            spawn_pulse  <= 1'b0;
            active_count <= '0;
        end else if (!enable) begin
            r_state      <= IDLE;
            r_spawn_cnt  <= '0;
            r_probe      <= '0;
            r_probe_cnt  <= '0;
            mole_led     <= '0;
            hit_pulse    <= 1'b0;
            hit_num      <= '0;
            miss_pulse   <= 1'b0;
            wrong_pulse  <= 1'b0;
            spawn_pulse  <= 1'b0;
            active_count <= '0;
        end else begin
            mole_led     <= w_led_next;
            active_count <= popcount(8'(w_led_next));
            hit_pulse    <= |w_hit;
            hit_num      <= (w_hit_cnt > 4'd7) ? 3'd7 : w_hit_cnt[2:0];
            miss_pulse   <= |w_timeout;
            wrong_pulse  <= w_wrong;
            spawn_pulse  <= |w_spawn_set;

            case (r_state)
                IDLE: begin
                    r_state     <= WAIT;
                    r_spawn_cnt <= spawn_reload(level);
                end
                WAIT: begin
                    if (r_spawn_cnt != '0) begin
                        r_spawn_cnt <= r_spawn_cnt - 1'b1;
                    end else if (int'(active_count) < MAX_ACTIVE) begin
                        r_state     <= PICK;
                        r_probe     <= c_PROBE_W'(w_rand % 8'(NUM_HOLES));
                        r_probe_cnt <= '0;
                    end else begin
                        r_spawn_cnt <= spawn_reload(level);
                    end
                end
                PICK: begin
                    if (|w_spawn_set || r_probe_cnt == 4'(NUM_HOLES - 1)) begin
                        r_state     <= WAIT;
                        r_spawn_cnt <= spawn_reload(level);
                    end else begin
                        r_probe     <= (r_probe == c_PROBE_W'(NUM_HOLES - 1)) ? '0 : r_probe + 1'b1;
                        r_probe_cnt <= r_probe_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mole_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_mole_scheduler
// Description : Randomized bench for mole_scheduler against a timestamp-based
//               reference model of spawn attempts and mole expiry.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mole_scheduler;

    localparam int N    = 5;
    localparam int MAXA = 2;
`ifdef MOLE_SCHED_PENALTY_EN
    localparam bit c_PEN = 1'b1;
`else
    localparam bit c_PEN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         r_enable;
    logic [1:0]   r_level;
    logic [N-1:0] r_hit_vec;
    logic [N-1:0] w_mole_led;
    logic         w_hit_pulse;
    logic [2:0]   w_hit_num;
    logic         w_miss_pulse;
    logic         w_wrong_pulse;
    logic         w_spawn_pulse;
    logic [3:0]   w_active_count;

    mole_scheduler #(
        .NUM_HOLES        (N),
        .MAX_ACTIVE       (MAXA),
        .SPAWN_TICKS_EASY (10),
        .SPAWN_TICKS_MED  (8),
        .SPAWN_TICKS_HARD (6),
        .LIFE_TICKS_EASY  (20),
        .LIFE_TICKS_MED   (15),
        .LIFE_TICKS_HARD  (12),
        .LFSR_SEED        (16'hACE1)
    ) dut (
        .clk          (clk),
        .reset        (rst),
        .enable       (r_enable),
        .level        (r_level),
        .hit_vec      (r_hit_vec),
        .mole_led     (w_mole_led),
        .hit_pulse    (w_hit_pulse),
        .hit_num      (w_hit_num),
        .miss_pulse   (w_miss_pulse),
        .wrong_pulse  (w_wrong_pulse),
        .spawn_pulse  (w_spawn_pulse),
        .active_count (w_active_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int spawn_of(input logic [1:0] l);
        return (l == 2'd0) ? 10 : (l == 2'd1) ? 8 : 6;
    endfunction

    function automatic int life_of(input logic [1:0] l);
        return (l == 2'd0) ? 20 : (l == 2'd1) ? 15 : 12;
    endfunction

    // Reference model: absolute cycle stamps for spawn attempts and expiries.
    int           t;
    bit           m_idle, m_probing;
    int           m_probe, m_left, m_next_attempt;
    bit [N-1:0]   m_lit;
    int           m_expire [N];
    logic [15:0]  m_lfsr;
    logic [N-1:0] e_led;
    logic         e_hit, e_miss, e_wrong, e_spawn;
    int           e_num, e_active;

    task automatic model_reset();
        t = 0; m_idle = 1; m_probing = 0; m_probe = 0; m_left = 0;
        m_next_attempt = 0; m_lit = '0; m_lfsr = 16'hACE1;
        for (int i = 0; i < N; i++) m_expire[i] = 0;
        e_led = '0; e_hit = 0; e_miss = 0; e_wrong = 0; e_spawn = 0;
        e_num = 0; e_active = 0;
    endtask

    task automatic model_step();
        bit [N-1:0] hits, miss, spawn;
        t++;
        if (!r_enable) begin
            m_idle = 1; m_probing = 0; m_lit = '0;
            e_led = '0; e_hit = 0; e_miss = 0; e_wrong = 0; e_spawn = 0;
            e_num = 0; e_active = 0;
        end else begin
            hits  = m_lit & r_hit_vec;
            miss  = '0;
            spawn = '0;
            for (int i = 0; i < N; i++)
                if (m_lit[i] && !r_hit_vec[i] && m_expire[i] == t) miss[i] = 1'b1;
            if (m_idle) begin
                m_idle = 0;
                m_next_attempt = t + spawn_of(r_level);
            end else if (m_probing) begin
                if (!m_lit[m_probe]) begin
                    spawn[m_probe] = 1'b1;
                    m_expire[m_probe] = t + life_of(r_level);
                    m_probing = 0;
                    m_next_attempt = t + spawn_of(r_level);
                end else begin
                    m_probe = (m_probe + 1) % N;
                    m_left--;
                    if (m_left == 0) begin
                        m_probing = 0;
                        m_next_attempt = t + spawn_of(r_level);
                    end
                end
            end else if (t == m_next_attempt) begin
                if ($countones(m_lit) < MAXA) begin
                    m_probing = 1;
                    m_probe = int'(m_lfsr[7:0]) % N;
                    m_left = N;
                end else begin
                    m_next_attempt = t + spawn_of(r_level);
                end
            end
            e_hit   = |hits;
            e_num   = $countones(hits);
            e_miss  = |miss;
            e_spawn = |spawn;
            e_wrong = c_PEN && (|(r_hit_vec & ~m_lit));
            m_lit   = (m_lit & ~hits & ~miss) | spawn;
            e_led   = m_lit;
            e_active = $countones(m_lit);
        end
        m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    endtask

    task automatic compare_all();
        check("mole_led", 32'(w_mole_led), 32'(e_led));
        check("hit_pulse", 32'(w_hit_pulse), 32'(e_hit));
        check("hit_num", 32'(w_hit_num), e_num);
        check("miss_pulse", 32'(w_miss_pulse), 32'(e_miss));
        check("wrong_pulse", 32'(w_wrong_pulse), 32'(e_wrong));
        check("spawn_pulse", 32'(w_spawn_pulse), 32'(e_spawn));
        check("active_count", 32'(w_active_count), e_active);
        check("active_le_max", 32'(int'(w_active_count) <= MAXA), 32'd1);
    endtask

    initial begin
        int          first_spawn;
        int          en_off;
        bit          did_rst, did_drop;
        logic [31:0] mask;

        first_spawn = -1; en_off = 0; did_rst = 0; did_drop = 0;
        rst = 1'b1; r_enable = 1'b0; r_level = 2'd0; r_hit_vec = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        compare_all();
        rst = 1'b0;
        r_enable = 1'b1;

        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(posedge clk);
            if (!rst) model_step();
            @(negedge clk);
            compare_all();
            if (first_spawn < 0 && w_spawn_pulse) first_spawn = cyc + 1;
            if (cyc == 20) check("first_spawn_in_time", 32'(first_spawn > 0 && first_spawn <= 10 + N), 32'd1);

            if (rst) begin
                rst = 1'b0;
            end else if (cyc > 300 && !did_rst && m_probing) begin
                did_rst = 1;
                #2 rst = 1'b1;
                #1;
                check("async_rst_led", 32'(w_mole_led), 32'd0);
                check("async_rst_spawn", 32'(w_spawn_pulse), 32'd0);
                check("async_rst_active", 32'(w_active_count), 32'd0);
                model_reset();
            end

            r_hit_vec = '0;
            if (cyc >= 200) begin
                if ($urandom_range(0, 49) == 0) r_level = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 3) == 0) begin
                    mask = $urandom;
                    r_hit_vec = r_hit_vec | (m_lit & mask[N-1:0]);
                end
                if ($urandom_range(0, 2) == 0)
                    for (int i = 0; i < N; i++)
                        if (m_lit[i] && m_expire[i] == t + 1) r_hit_vec[i] = 1'b1;
                if ($urandom_range(0, 19) == 0) r_hit_vec[$urandom_range(0, N - 1)] = 1'b1;

                if (en_off > 0) en_off--;
                else if (!did_drop && $countones(m_lit) == 2) begin
                    did_drop = 1;
                    en_off = 3;
                end else if ($urandom_range(0, 149) == 0) en_off = $urandom_range(1, 5);
                r_enable = (en_off == 0);
            end
        end

        check("saw_async_reset", 32'(did_rst), 32'd1);
        check("saw_enable_drop", 32'(did_drop), 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
